// File: rtl/pong_graphic_engine.sv
// rtl/pong_graphic_engine.sv - animated pong pixel generator: wall, paddle, bouncing ball, registered rgb
//
// Purpose: holds paddle and ball state, moves both once per frame on the
// refresh tick (pixel (0, V_RES+1)), resolves object priority
// wall > bar > ball > background, and drives a registered 12-bit colour.
//
// Ports:
//   clk       pixel clock
//   rst       synchronous reset, active-low
//   video_on  visible-area flag from the sync generator
//   pixel_x   current column (10 bits)
//   pixel_y   current line (10 bits)
//   btn_up    paddle up, level, pre-debounced
//   btn_down  paddle down, level, pre-debounced
//   rgb       registered pixel colour, one clk after pixel_x/pixel_y/video_on
//   miss      one-clk pulse when the ball leaves past the right edge
//
// Configuration macro: ROUND_BALL_EN
//   defined   -> ball drawn from an 8x8 round-shape ROM (BALL_SZ must be 8)
//   undefined -> ball drawn as a full BALL_SZ square, no ROM
module pong_graphic_engine #(
  parameter int          H_RES    = 640,
  parameter int          V_RES    = 480,
  parameter int          WALL_XL  = 32,
  parameter int          WALL_XR  = 35,
  parameter int          BAR_XL   = 600,
  parameter int          BAR_XR   = 603,
  parameter int          BAR_H    = 72,
  parameter int          BAR_V    = 4,
  parameter int          BALL_SZ  = 8,
  parameter int          BALL_V   = 2,
  parameter logic [11:0] WALL_RGB = 12'h00F,
  parameter logic [11:0] BAR_RGB  = 12'h0F0,
  parameter logic [11:0] BALL_RGB = 12'hF00,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] rgb,
  output logic        miss
);

  localparam logic [9:0] X_LIMIT   = 10'(H_RES);
  localparam logic [9:0] TICK_Y    = 10'(V_RES + 1);
  localparam logic [9:0] W_XL      = 10'(WALL_XL);
  localparam logic [9:0] W_XR      = 10'(WALL_XR);
  localparam logic [9:0] B_XL      = 10'(BAR_XL);
  localparam logic [9:0] B_XR      = 10'(BAR_XR);
  localparam logic [9:0] B_SPAN    = 10'(BAR_H - 1);
  localparam logic [9:0] B_STEP    = 10'(BAR_V);
  localparam logic [9:0] B_LOW_LIM = 10'(V_RES - 1 - BAR_V);
  localparam logic [9:0] BALL_SPAN = 10'(BALL_SZ - 1);
  localparam logic [9:0] BALL_DIM  = 10'(BALL_SZ);
  localparam logic [9:0] Y_BOUNCE  = 10'(V_RES - 2);
  localparam logic [9:0] VEL_POS   = 10'(BALL_V);
  localparam logic [9:0] VEL_NEG   = 10'(-BALL_V);
  localparam logic [9:0] BAR_RST   = 10'((V_RES - BAR_H) / 2);
  localparam logic [9:0] BALL_X0   = 10'((H_RES - BALL_SZ) / 2);
  localparam logic [9:0] BALL_Y0   = 10'((V_RES - BALL_SZ) / 2);

  logic [9:0]  bar_top, ball_x, ball_y, dx, dy;
  logic [9:0]  bar_bot, ball_r, ball_b;
  logic [9:0]  dx_next, dy_next;
  logic [9:0]  off_x, off_y;
  logic        refr_tick, up_ok, down_ok;
  logic        wall_on, bar_on, ball_on, in_square;
  logic [11:0] color;

  assign refr_tick = (pixel_x == 10'd0) && (pixel_y == TICK_Y);

  assign bar_bot = bar_top + B_SPAN;
  assign ball_r  = ball_x + BALL_SPAN;
  assign ball_b  = ball_y + BALL_SPAN;

  assign up_ok   = btn_up && !btn_down && (bar_top > B_STEP);
  assign down_ok = btn_down && !btn_up && (bar_bot < B_LOW_LIM);

  // Direction is chosen from the pre-move position while the move itself
  // uses the old delta, so the ball may overshoot an edge by one step.
  // All sums are 10-bit, so a ball at y=-2 (1022) is not mistaken for the
  // bottom edge and recovers on the following tick.
  always_comb begin
    dy_next = dy;
    if (ball_y <= 10'd1) begin
      dy_next = VEL_POS;
    end else if (ball_b >= Y_BOUNCE) begin
      dy_next = VEL_NEG;
    end
    dx_next = dx;
    if (ball_x <= W_XR) begin
      dx_next = VEL_POS;
    end else if ((ball_r >= B_XL) && (ball_r <= B_XR) &&
                 (ball_b >= bar_top) && (ball_y <= bar_bot)) begin
      dx_next = VEL_NEG;
    end
  end

  // Offsets wrap, so a ball partly above row 0 still draws its lower rows.
  assign off_x     = pixel_x - ball_x;
  assign off_y     = pixel_y - ball_y;
  assign in_square = (off_x < BALL_DIM) && (off_y < BALL_DIM);

`ifdef ROUND_BALL_EN
  logic [7:0] rom_row;

  always_comb begin
    rom_row = 8'h00;
    case (off_y[2:0])
      3'd0:    rom_row = 8'h3C;
      3'd1:    rom_row = 8'h7E;
      3'd2:    rom_row = 8'hFF;
      3'd3:    rom_row = 8'hFF;
      3'd4:    rom_row = 8'hFF;
      3'd5:    rom_row = 8'hFF;
      3'd6:    rom_row = 8'h7E;
      default: rom_row = 8'h3C;
    endcase
  end

  // Column 0 is the MSB of each ROM row.
  assign ball_on = in_square && rom_row[3'd7 - off_x[2:0]];
`else
  assign ball_on = in_square;
`endif

  assign wall_on = (pixel_x >= W_XL) && (pixel_x <= W_XR);
  assign bar_on  = (pixel_x >= B_XL) && (pixel_x <= B_XR) &&
                   (pixel_y >= bar_top) && (pixel_y <= bar_bot);

  always_comb begin
    color = BG_RGB;
    if (wall_on) begin
      color = WALL_RGB;
    end else if (bar_on) begin
      color = BAR_RGB;
    end else if (ball_on) begin
      color = BALL_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb     <= 12'h000;
      miss    <= 1'b0;
      bar_top <= BAR_RST;
      ball_x  <= BALL_X0;
      ball_y  <= BALL_Y0;
      dx      <= VEL_POS;
      dy      <= VEL_POS;
    end else begin
      rgb  <= video_on ? color : 12'h000;
      miss <= 1'b0;
      if (refr_tick) begin
        if (up_ok) begin
          bar_top <= bar_top - B_STEP;
        end else if (down_ok) begin
          bar_top <= bar_top + B_STEP;
        end
        if (ball_x >= X_LIMIT) begin
          ball_x <= BALL_X0;
          ball_y <= BALL_Y0;
          dx     <= VEL_POS;
          dy     <= VEL_POS;
          miss   <= 1'b1;
        end else begin
          ball_x <= ball_x + dx;
          ball_y <= ball_y + dy;
          dx     <= dx_next;
          dy     <= dy_next;
        end
      end
    end
  end

endmodule
